// File: rtl/systolic_feed_controller_if.sv
// Command and feeder-side signal bundle for the systolic array sequencer.
// The controller uses the slave modport; the host/feeder side uses master.
interface systolic_feed_controller_if #(
    parameter int N     = 4,
    parameter int K_MAX = 16
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int IW = $clog2(K_MAX);

    logic            START;
    logic            ABORT;
    logic [KW-1:0]   K_LEN;
    logic            BUSY;
    logic            DONE;
    logic            ERR;
    logic            ARRAY_RST_N;
    logic [N-1:0]    LANE_VALID;
    logic [N*IW-1:0] LANE_IDX;

    modport master (
        output START, ABORT, K_LEN,
        input  BUSY, DONE, ERR, ARRAY_RST_N, LANE_VALID, LANE_IDX
    );

    modport slave (
        input  START, ABORT, K_LEN,
        output BUSY, DONE, ERR, ARRAY_RST_N, LANE_VALID, LANE_IDX
    );
endinterface

// File: rtl/systolic_feed_controller.sv
// Sequencer for an N x N output-stationary systolic array: clears the PE
// accumulators, walks a skewed per-lane operand index wavefront across the
// array edges, waits for the pipeline to drain and then pulses DONE.
// Every output is a register loaded from the next-state values, so the
// outputs line up with the state being entered.
module systolic_feed_controller #(
    parameter int N      = 4,
    parameter int K_MAX  = 16,
    parameter int PE_LAT = 3
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    systolic_feed_controller_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int IW = $clog2(K_MAX);
    // Step counter covers both FEED (up to K_MAX+N-2) and DRAIN, and leaves
    // headroom for the i+K lane upper bound so that compare never wraps.
    localparam int TW = $clog2(K_MAX + N + PE_LAT);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(N - 2 + PE_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [TW-1:0]   t_r, t_s;
    logic [KW-1:0]   k_r, k_s;
    logic            k_ok_s;
    logic [TW-1:0]   feed_last_s;
    logic            err_s, done_s;
    logic [N-1:0]    lane_valid_s;
    logic [N*IW-1:0] lane_idx_s;

    logic            busy_r, done_r, err_r, array_rst_n_r;
    logic [N-1:0]    lane_valid_r;
    logic [N*IW-1:0] lane_idx_r;

    // Qualify the requested inner dimension and find the final FEED step.
    always_comb begin
        k_ok_s      = (bus.K_LEN != {KW{1'b0}}) && (bus.K_LEN <= KW'(K_MAX));
        feed_last_s = TW'(k_r) + TW'(N - 2);
    end

    // Next-state, step counter, latched K and the ERR/DONE pulse requests.
    always_comb begin
        state_s = state_r;
        t_s     = t_r;
        k_s     = k_r;
        err_s   = 1'b0;
        done_s  = 1'b0;
        if (bus.ABORT) begin
            state_s = IDLE;
            t_s     = {TW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.START && k_ok_s) begin
                        state_s = CLEAR;
                        k_s     = bus.K_LEN;
                    end else if (bus.START) begin
                        err_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CLEAR: begin
                    state_s = FEED;
                    t_s     = {TW{1'b0}};
                end
                FEED: begin
                    if (t_r == feed_last_s) begin
                        state_s = DRAIN;
                        t_s     = {TW{1'b0}};
                    end else begin
                        t_s = t_r + TW'(1);
                    end
                end
                DRAIN: begin
                    if (t_r == DRAIN_LAST) begin
                        state_s = IDLE;
                        t_s     = {TW{1'b0}};
                        done_s  = 1'b1;
                    end else begin
                        t_s = t_r + TW'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    t_s     = {TW{1'b0}};
                end
            endcase
        end
    end

    // Skewed wavefront: lane i is live for steps i .. i+K-1 and shows T-i.
    always_comb begin
        lane_valid_s = {N{1'b0}};
        lane_idx_s   = {(N*IW){1'b0}};
        for (int i = 0; i < N; i++) begin
            if ((state_s == FEED) && (t_s >= TW'(i)) && (t_s < (TW'(i) + TW'(k_s)))) begin
                lane_valid_s[i]        = 1'b1;
                lane_idx_s[i*IW +: IW] = IW'(t_s - TW'(i));
            end else begin
                lane_valid_s[i] = 1'b0;
            end
        end
    end

    // Sequencer state, step counter and latched inner dimension.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            t_r     <= {TW{1'b0}};
            k_r     <= {KW{1'b0}};
        end else begin
            state_r <= state_s;
            t_r     <= t_s;
            k_r     <= k_s;
        end
    end

    // Output registers, loaded with the values of the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            array_rst_n_r <= 1'b0;
            lane_valid_r  <= {N{1'b0}};
            lane_idx_r    <= {(N*IW){1'b0}};
        end else begin
            busy_r        <= (state_s != IDLE);
            done_r        <= done_s;
            err_r         <= err_s;
            array_rst_n_r <= (state_s != CLEAR);
            lane_valid_r  <= lane_valid_s;
            lane_idx_r    <= lane_idx_s;
        end
    end

    assign bus.BUSY        = busy_r;
    assign bus.DONE        = done_r;
    assign bus.ERR         = err_r;
    assign bus.ARRAY_RST_N = array_rst_n_r;
    assign bus.LANE_VALID  = lane_valid_r;
    assign bus.LANE_IDX    = lane_idx_r;
endmodule

// File: tb/tb_systolic_feed_controller.sv
// Self-checking bench: directed scenarios followed by random command traffic,
// every cycle compared against a run-offset reference model.
module tb_systolic_feed_controller;
    localparam int N      = 4;
    localparam int K_MAX  = 16;
    localparam int PE_LAT = 3;
    localparam int IW     = $clog2(K_MAX);

    logic clk_s   = 1'b0;
    logic rst_n_s = 1'b0;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    // Reference model: a run is described only by how many edges have passed
    // since its START was accepted (run_d) and its inner dimension (run_k).
    bit run_active = 1'b0;
    int run_d      = 0;
    int run_k      = 0;
    bit seen_edge  = 1'b0;
    bit exp_err    = 1'b0;
    bit exp_done   = 1'b0;

    systolic_feed_controller_if #(.N(N), .K_MAX(K_MAX)) bus ();

    systolic_feed_controller #(.N(N), .K_MAX(K_MAX), .PE_LAT(PE_LAT)) dut (
        .CLK   (clk_s),
        .RST_N (rst_n_s),
        .bus   (bus.slave)
    );

    always #5 clk_s = ~clk_s;

    // Compare one observed value with its expected value and log mismatches.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_rst();
        run_active = 1'b0;
        run_d      = 0;
        run_k      = 0;
        seen_edge  = 1'b0;
        exp_err    = 1'b0;
        exp_done   = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held over it.
    task automatic model_edge();
        int total;
        exp_err   = 1'b0;
        exp_done  = 1'b0;
        seen_edge = 1'b1;
        if (bus.ABORT) begin
            run_active = 1'b0;
        end else if (!run_active) begin
            if (bus.START) begin
                if (int'(bus.K_LEN) >= 1 && int'(bus.K_LEN) <= K_MAX) begin
                    run_active = 1'b1;
                    run_d      = 1;
                    run_k      = int'(bus.K_LEN);
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else begin
            run_d++;
            total = 1 + (run_k + N - 1) + (N - 1 + PE_LAT) + 1;
            if (run_d == total) begin
                run_active = 1'b0;
                exp_done   = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0]    e_valid;
        logic [N*IW-1:0] e_idx;
        logic [IW-1:0]   one_idx;
        int              t;
        e_valid = '0;
        e_idx   = '0;
        t       = run_d - 2;
        if (run_active && run_d >= 2 && run_d <= run_k + N) begin
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < i + run_k) begin
                    e_valid[i]        = 1'b1;
                    one_idx           = IW'(t - i);
                    e_idx[i*IW +: IW] = one_idx;
                end
            end
        end
        check_eq({tag, ".busy"},  64'(bus.BUSY),        64'(run_active));
        check_eq({tag, ".done"},  64'(bus.DONE),        64'(exp_done));
        check_eq({tag, ".err"},   64'(bus.ERR),         64'(exp_err));
        check_eq({tag, ".arst"},  64'(bus.ARRAY_RST_N), 64'(seen_edge && !(run_active && run_d == 1)));
        check_eq({tag, ".valid"}, 64'(bus.LANE_VALID),  64'(e_valid));
        check_eq({tag, ".idx"},   64'(bus.LANE_IDX),    64'(e_idx));
    endtask

    // Advance one clock: model follows the edge, outputs checked on the low phase.
    task automatic step(input string tag);
        @(posedge clk_s);
        if (rst_n_s) begin
            model_edge();
        end
        @(negedge clk_s);
        compare_all(tag);
    endtask

    task automatic set_in(input bit st, input bit ab, input int k);
        bus.START = st;
        bus.ABORT = ab;
        bus.K_LEN = 5'(k);
    endtask

    initial begin
        int r;
        model_rst();
        set_in(1'b0, 1'b0, 0);
        @(negedge clk_s);
        compare_all("reset");
        step("reset");
        step("reset");
        rst_n_s = 1'b1;
        step("release");

        // Single run, K=4.
        set_in(1'b1, 1'b0, 4);
        step("k4");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 16; c++) step("k4");

        // Rejected lengths.
        set_in(1'b1, 1'b0, 0);
        step("k0");
        set_in(1'b0, 1'b0, 0);
        step("k0");
        set_in(1'b1, 1'b0, 17);
        step("k17");
        set_in(1'b0, 1'b0, 0);
        step("k17");

        // Abort during FEED, then a full run.
        set_in(1'b1, 1'b0, 4);
        step("abort");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 4; c++) step("abort");
        set_in(1'b1, 1'b1, 4);
        step("abort");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 3; c++) step("abort");
        set_in(1'b1, 1'b0, 4);
        step("rerun");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 16; c++) step("rerun");

        // START held high: back-to-back K=1 runs, mid-run STARTs ignored.
        set_in(1'b1, 1'b0, 1);
        for (int c = 0; c < 30; c++) step("held");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 14; c++) step("held");

        // Asynchronous reset while draining.
        set_in(1'b1, 1'b0, 4);
        step("arst");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 10; c++) step("arst");
        #2;
        rst_n_s = 1'b0;
        #1;
        model_rst();
        compare_all("arst.async");
        step("arst.hold");
        step("arst.hold");
        rst_n_s = 1'b1;
        step("arst.rel");

        // Largest inner dimension.
        set_in(1'b1, 1'b0, K_MAX);
        step("kmax");
        set_in(1'b0, 1'b0, 0);
        for (int c = 0; c < 30; c++) step("kmax");

        // Random command traffic.
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 9));
            bus.START = ($urandom_range(0, 3) == 0);
            bus.ABORT = ($urandom_range(0, 49) == 0);
            if (r == 0) begin
                bus.K_LEN = 5'd0;
            end else if (r == 1) begin
                bus.K_LEN = 5'($urandom_range(K_MAX + 1, 31));
            end else begin
                bus.K_LEN = 5'($urandom_range(1, K_MAX));
            end
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule
